// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: memory-access stage driving a request/ready data bus and the MEM/WB register.
// Optional feature macro: MISALIGN_TRAP_EN (trap misaligned half/word accesses instead of issuing them).
module mem_stage_lsu #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] mem_alu_result,
    input  logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic [ADDR_WIDTH-1:0] mem_daddr,
    input  logic                  mem_mem_write,
    input  logic                  mem_mem_read,
    input  logic [2:0]            mem_funct3,
    input  logic [4:0]            mem_reg_dest,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    output logic [3:0]            dmem_wstrb,
    input  logic                  dmem_ready,
    input  logic [DATA_WIDTH-1:0] dmem_rdata,
    output logic                  stall,
    output logic [DATA_WIDTH-1:0] wb_result,
    output logic [4:0]            wb_reg_dest,
    output logic                  wb_reg_write,
    output logic                  misalign
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t                state, state_next;
    logic                  access, access_bus, mis, is_load;
    logic [1:0]            o;
    logic [DATA_WIDTH-1:0] rshift, load_data, wb_next_result;
    logic [15:0]           half_v;
    logic                  wb_next_write;

    assign o       = mem_daddr[1:0];
    assign access  = mem_mem_read | mem_mem_write;
    assign is_load = mem_mem_read & ~mem_mem_write;

`ifdef MISALIGN_TRAP_EN
    assign mis = access & ((((mem_funct3 == 3'b001) | (is_load & (mem_funct3 == 3'b101))) & o[0])
                         | ((mem_funct3 == 3'b010) & (o != 2'b00)));
`else
    assign mis = 1'b0;
`endif

    // A trapped access never reaches the bus, so it neither requests nor stalls.
    assign access_bus = access & ~mis;
    assign stall      = access_bus & ~((state == WAIT) & dmem_ready);
    assign dmem_addr  = {mem_daddr[ADDR_WIDTH-1:2], 2'b00};

    // State register plus the write-enable latched when the request is launched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            dmem_we <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && access_bus)
                dmem_we <= mem_mem_write;
            else if (state == WAIT && dmem_ready)
                dmem_we <= 1'b0;
        end
    end

    // Next state: launch on any bus access, finish when the bus reports ready.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = access_bus ? WAIT : IDLE;
            WAIT:    state_next = dmem_ready ? IDLE : WAIT;
            default: state_next = IDLE;
        endcase
    end

    // Request is high exactly while waiting, so it comes straight off the state flop.
    always_comb begin
        dmem_req = (state == WAIT);
    end

    // Store lane steering: replicate the narrow datum and strobe the addressed lanes.
    always_comb begin
        dmem_wstrb = 4'b1111;
        dmem_wdata = mem_write_data;
        case (mem_funct3)
            3'b000: begin
                dmem_wstrb = 4'b0001 << o;
                dmem_wdata = {4{mem_write_data[7:0]}};
            end
            3'b001: begin
                dmem_wstrb = o[1] ? 4'b1100 : 4'b0011;
                dmem_wdata = {2{mem_write_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Load extraction: bytes use the full offset, halves only the upper offset bit.
    always_comb begin
        rshift    = dmem_rdata >> {o, 3'b000};
        half_v    = o[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        load_data = dmem_rdata;
        case (mem_funct3)
            3'b000:  load_data = {{24{rshift[7]}}, rshift[7:0]};
            3'b100:  load_data = {24'h0, rshift[7:0]};
            3'b001:  load_data = {{16{half_v[15]}}, half_v};
            3'b101:  load_data = {16'h0, half_v};
            default: ;
        endcase
        wb_next_result = (is_load & ~mis) ? load_data : mem_alu_result;
        wb_next_write  = ~mem_mem_write & ~mis & (mem_reg_dest != 5'd0);
    end

    // MEM/WB register: flush wins, otherwise capture whenever the pipe is not stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_result    <= '0;
            wb_reg_dest  <= '0;
            wb_reg_write <= 1'b0;
            misalign     <= 1'b0;
        end else if (flush) begin
            wb_result    <= '0;
            wb_reg_dest  <= '0;
            wb_reg_write <= 1'b0;
            misalign     <= 1'b0;
        end else if (!stall) begin
            wb_result    <= wb_next_result;
            wb_reg_dest  <= mem_reg_dest;
            wb_reg_write <= wb_next_write;
            misalign     <= mis;
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: directed and random transactions on mem_stage_lsu checked against a byte-level model.
module tb_mem_stage_lsu;

    logic        clk, rst_n, flush;
    logic [31:0] mem_alu_result, mem_write_data, mem_daddr;
    logic        mem_mem_write, mem_mem_read;
    logic [2:0]  mem_funct3;
    logic [4:0]  mem_reg_dest;
    logic        dmem_req, dmem_we, dmem_ready, stall, wb_reg_write, misalign;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, wb_result;
    logic [3:0]  dmem_wstrb;
    logic [4:0]  wb_reg_dest;

    int errors = 0;
    int checks = 0;

    mem_stage_lsu dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .mem_alu_result(mem_alu_result), .mem_write_data(mem_write_data),
        .mem_daddr(mem_daddr), .mem_mem_write(mem_mem_write), .mem_mem_read(mem_mem_read),
        .mem_funct3(mem_funct3), .mem_reg_dest(mem_reg_dest),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_ready(dmem_ready),
        .dmem_rdata(dmem_rdata), .stall(stall), .wb_result(wb_result),
        .wb_reg_dest(wb_reg_dest), .wb_reg_write(wb_reg_write), .misalign(misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference load value computed from byte/half arithmetic on the read word.
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input int o, input logic [31:0] rd);
        logic [31:0] b, h;
        b = (rd >> (8 * o)) & 32'hFF;
        h = (rd >> (16 * (o / 2))) & 32'hFFFF;
        case (f3)
            3'b000:  return b - ((b >= 128) ? 32'd256 : 32'd0);
            3'b100:  return b;
            3'b001:  return h - ((h >= 32768) ? 32'd65536 : 32'd0);
            3'b101:  return h;
            default: return rd;
        endcase
    endfunction

    task automatic idle_inputs();
        mem_mem_read = 0; mem_mem_write = 0; mem_funct3 = 0; mem_daddr = 0;
        mem_write_data = 0; mem_alu_result = 0; mem_reg_dest = 0;
        flush = 0; dmem_ready = 0; dmem_rdata = 0;
    endtask

    // One instruction through the stage; called at posedge+1, returns at posedge+1 after capture.
    task automatic do_op(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] alu, input logic [4:0] dest,
                         input int lat, input bit fl);
        logic [31:0] exp_res, exp_wdata, rdat;
        logic [3:0]  exp_strb;
        bit          exp_wr;
        int          o;
        o = int'(addr[1:0]);
        mem_mem_read = rd; mem_mem_write = wr; mem_funct3 = f3; mem_daddr = addr;
        mem_write_data = wd; mem_alu_result = alu; mem_reg_dest = dest;
        exp_res = alu;
        exp_wr  = !wr && dest != 0;
        case (f3)
            3'b000: begin exp_strb = 4'(1 << o); exp_wdata = (wd & 32'hFF) * 32'h0101_0101; end
            3'b001: begin exp_strb = 4'(3 << (2 * (o / 2))); exp_wdata = (wd & 32'hFFFF) * 32'h0001_0001; end
            default: begin exp_strb = 4'hF; exp_wdata = wd; end
        endcase
        if (rd || wr) begin
            @(negedge clk);
            chk("issue_stall", 32'(stall), 1);
            chk("issue_req", 32'(dmem_req), 0);
            @(posedge clk); #1;
            for (int k = 0; k <= lat; k++) begin
                rdat = $urandom;
                dmem_rdata = rdat;
                dmem_ready = (k == lat);
                flush = (k == lat) ? fl : 1'b0;
                if (k == lat && rd && !wr) exp_res = ref_load(f3, o, rdat);
                @(negedge clk);
                chk("wait_req", 32'(dmem_req), 1);
                chk("wait_we", 32'(dmem_we), 32'(wr));
                chk("wait_addr", dmem_addr, addr & 32'hFFFF_FFFC);
                if (wr) begin
                    chk("wait_wstrb", 32'(dmem_wstrb), 32'(exp_strb));
                    chk("wait_wdata", dmem_wdata, exp_wdata);
                end
                chk("wait_stall", 32'(stall), 32'(k != lat));
                @(posedge clk); #1;
            end
            dmem_ready = 0;
        end else begin
            flush = fl;
            @(negedge clk);
            chk("pass_stall", 32'(stall), 0);
            @(posedge clk); #1;
        end
        flush = 0;
        chk("wb_result", wb_result, fl ? 32'd0 : exp_res);
        chk("wb_reg_write", 32'(wb_reg_write), fl ? 32'd0 : 32'(exp_wr));
        chk("wb_reg_dest", 32'(wb_reg_dest), fl ? 32'd0 : 32'(dest));
        chk("wb_misalign", 32'(misalign), 0);
        chk("post_req", 32'(dmem_req), 0);
        idle_inputs();
    endtask

    initial begin
        rst_n = 0;
        idle_inputs();
        #2;
        chk("rst_req", 32'(dmem_req), 0);
        chk("rst_we", 32'(dmem_we), 0);
        chk("rst_wb_result", wb_result, 0);
        chk("rst_wb_dest", 32'(wb_reg_dest), 0);
        chk("rst_wb_write", 32'(wb_reg_write), 0);
        chk("rst_misalign", 32'(misalign), 0);
        @(posedge clk); #1;
        rst_n = 1;
        do_op(0, 0, 3'b000, 32'h0, 32'h0, 32'h1234_5678, 5'd5, 0, 0);
        do_op(1, 0, 3'b000, 32'h103, 32'h0, 32'hAAAA_0000, 5'd7, 0, 0);
        do_op(0, 1, 3'b001, 32'h2002, 32'h0000_BEEF, 32'h5555, 5'd9, 3, 0);
        do_op(0, 0, 3'b000, 32'h0, 32'h0, 32'h7, 5'd0, 0, 0);
        do_op(1, 0, 3'b010, 32'h40, 32'h0, 32'h1, 5'd3, 1, 1);
        do_op(0, 0, 3'b000, 32'h0, 32'h0, 32'hDEAD_BEEF, 5'd1, 0, 1);
        do_op(1, 0, 3'b010, 32'h06, 32'h0, 32'h0, 5'd12, 0, 0);
        do_op(1, 1, 3'b000, 32'h11, 32'hA5, 32'h9, 5'd4, 2, 0);
        do_op(0, 0, 3'b000, 32'h0, 32'h0, 32'hCAFE_F00D, 5'd31, 0, 0);
        // Reset while a load waits on the bus.
        mem_mem_read = 1; mem_funct3 = 3'b010; mem_daddr = 32'h80; mem_reg_dest = 5'd6;
        @(posedge clk); #1;
        chk("pre_rst_req", 32'(dmem_req), 1);
        #2 rst_n = 0;
        #1;
        chk("arst_req", 32'(dmem_req), 0);
        chk("arst_wb_result", wb_result, 0);
        chk("arst_wb_write", 32'(wb_reg_write), 0);
        chk("arst_wb_dest", 32'(wb_reg_dest), 0);
        idle_inputs();
        @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;
        chk("post_rst_req", 32'(dmem_req), 0);
        for (int n = 0; n < 80; n++) begin
            int kind;
            kind = int'($urandom % 4);
            do_op(kind == 1 || kind == 3, kind >= 2, 3'($urandom), $urandom, $urandom, $urandom,
                  5'($urandom), int'($urandom % 4), ($urandom % 8) == 0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
